// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM port, decode valid/ready handshake, redirect and debug PC.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_if;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;

  modport master (
    input  fetch_en, rom_data, out_ready, redirect_valid, redirect_pc,
    output rom_addr, out_valid, out_instr, out_pc, fetch_pc
  );

  modport slave (
    output fetch_en, rom_data, out_ready, redirect_valid, redirect_pc,
    input  rom_addr, out_valid, out_instr, out_pc, fetch_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32E fetch stage: owns the PC, reads a zero-latency ROM and queues {pc, instr}
// pairs in a small circular buffer feeding decode; a redirect flushes and reloads.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic deq;
  logic enq;

  assign bus.rom_addr  = pc_q;
  assign bus.fetch_pc  = pc_q;
  assign bus.out_valid = (count_q != '0);
  // Gating by out_valid gives zero outputs in reset without resetting storage.
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q].instr : 32'h0;
  assign bus.out_pc    = bus.out_valid ? mem_q[rd_ptr_q].pc    : 32'h0;

  assign deq = bus.out_valid & bus.out_ready;
  assign enq = bus.fetch_en & ~bus.redirect_valid & ((count_q < DEPTH_C) | deq);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    if (enq) begin
      mem_d[wr_ptr_q] = '{pc: pc_q, instr: bus.rom_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      pc_d            = pc_q + 32'd4;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect wins: a same-cycle dequeue still hands its entry to decode,
    // everything left in the buffer is dropped.
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: buffer storage is deliberately not reset; count_q alone marks entries valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one default-vector instance and one whose
// reset vector sits just below 2^32 so the PC wrap is exercised.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  instr_fetch_if bus ();
  instr_fetch_if bus_w ();

  instr_fetch #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  // ORI x1,x0,3 / SLTI x2,x1,5 / ADDI xi,x0,i ... / NOP
  logic [31:0] rom [16];
  initial begin
    rom[0]  = 32'h0030_6093;
    rom[1]  = 32'h0050_A113;
    rom[2]  = 32'h0020_0113;
    rom[3]  = 32'h0030_0193;
    rom[4]  = 32'h0040_0213;
    rom[5]  = 32'h0050_0293;
    rom[6]  = 32'h0060_0313;
    rom[7]  = 32'h0070_0393;
    rom[8]  = 32'h0080_0413;
    rom[9]  = 32'h0090_0493;
    rom[10] = 32'h00A0_0513;
    rom[11] = 32'h00B0_0593;
    rom[12] = 32'h00C0_0613;
    rom[13] = 32'h00D0_0693;
    rom[14] = 32'h00E0_0713;
    rom[15] = 32'h0000_0013;
  end

  // Zero-latency ROM models; the address wraps over 16 words.
  always_comb bus.rom_data   = rom[bus.rom_addr[5:2]];
  always_comb bus_w.rom_data = rom[bus_w.rom_addr[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n                = 1'b0;
    bus.fetch_en         = 1'b1;
    bus.out_ready        = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = 32'h0;
    bus_w.fetch_en       = 1'b1;
    bus_w.out_ready      = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid",     {31'b0, bus.out_valid}, 32'd0);
    check("rst_rom_addr",  bus.rom_addr,  32'h0);
    check("rst_out_pc",    bus.out_pc,    32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_wrap_pc",   bus_w.fetch_pc, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    // Streaming, one per cycle; wrap instance crosses 2^32
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("str_valid", {31'b0, bus.out_valid}, 32'd1);
      check("str_pc",    bus.out_pc,    32'(4 * i));
      check("str_instr", bus.out_instr, rom[i]);
      check("wrap_pc",    bus_w.out_pc,    32'hFFFF_FFF8 + 32'(4 * i));
      check("wrap_instr", bus_w.out_instr, rom[(14 + i) % 16]);
    end

    // Back-pressure from reset: buffer fills, PC holds at 8
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("bp_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_fetch_pc", bus.fetch_pc,  32'h8);
    check("bp_head_pc",  bus.out_pc,    32'h0);
    check("bp_head_ins", bus.out_instr, rom[0]);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("bp_drain_pc", bus.out_pc, 32'(4 * i));
      check("bp_drain_v",  {31'b0, bus.out_valid}, 32'd1);
    end

    // Redirect while full (head pc 12, pc 16 behind it)
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_pc     = 32'h13;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
    check("rdf_valid",    {31'b0, bus.out_valid}, 32'd0);
    check("rdf_rom_addr", bus.rom_addr, 32'h10);
    @(negedge clk);
    check("rdf_tgt_valid", {31'b0, bus.out_valid}, 32'd1);
    check("rdf_tgt_pc",    bus.out_pc,    32'h10);
    check("rdf_tgt_instr", bus.out_instr, rom[4]);

    // Asynchronous reset between edges mid-stream
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid",    {31'b0, bus.out_valid}, 32'd0);
    check("ar_rom_addr", bus.rom_addr, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_restart_pc", bus.out_pc, 32'h0);

    // Redirect together with the handshake on pc 4: pc 8 must be dropped
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rdh_head_pc", bus.out_pc, 32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("rdh_valid",    {31'b0, bus.out_valid}, 32'd0);
    check("rdh_fetch_pc", bus.fetch_pc, 32'h20);
    @(negedge clk);
    check("rdh_tgt_pc",    bus.out_pc,    32'h20);
    check("rdh_tgt_instr", bus.out_instr, rom[8]);

    // fetch_en low: buffer drains, PC holds
    bus.fetch_en = 1'b0;
    @(negedge clk);
    check("fe_valid",    {31'b0, bus.out_valid}, 32'd0);
    check("fe_fetch_pc", bus.fetch_pc, 32'h24);
    @(negedge clk);
    check("fe_hold_pc",  bus.fetch_pc, 32'h24);

    // Held redirect: PC reloaded each cycle, buffer stays empty
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3C;
    @(negedge clk);
    check("rdl_valid0", {31'b0, bus.out_valid}, 32'd0);
    bus.redirect_pc    = 32'h42;
    @(negedge clk);
    check("rdl_valid1", {31'b0, bus.out_valid}, 32'd0);
    check("rdl_pc",     bus.fetch_pc, 32'h40);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("rdl_tgt_pc",    bus.out_pc,    32'h40);
    check("rdl_tgt_instr", bus.out_instr, rom[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
